cdb_arbiter: RTL and testbench

// - Common-data-bus (CDB) arbiter: receives completed results from the ADD and MUL functional units and

---
 rtl/tomasulo_pkg.sv | 14 +
 rtl/result_fifo.sv | 51 +++++
 rtl/cdb_arbiter.sv | 106 ++++++++++
 tb/tb_cdb_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: result/tag widths, the reserved "no producer" tag
// and the CDB source encoding.
package tomasulo_pkg;

  localparam int DATA_W   = 8;
  localparam int TAG_W    = 3;
  localparam int TAG_NONE = 0;

  typedef enum logic {
    SRC_ADD = 1'b0,
    SRC_MUL = 1'b1
  } src_t;

endpackage

// File: rtl/result_fifo.sv
// In-order result buffer for one functional unit. The caller only pushes when
// not full and only pops when not empty; there is no fall-through path.
module result_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage carries no reset; validity is tracked purely by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (PTR_W + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers ADD and MUL results and broadcasts at most one
// (tag, value) per cycle, alternating fairly when both queues hold work.
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int DATA_W = tomasulo_pkg::DATA_W,
  parameter int TAG_W  = tomasulo_pkg::TAG_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              add_valid,
  input  logic [DATA_W-1:0] add_data,
  input  logic [TAG_W-1:0]  add_tag,
  output logic              add_ready,
  input  logic              mul_valid,
  input  logic [DATA_W-1:0] mul_data,
  input  logic [TAG_W-1:0]  mul_tag,
  output logic              mul_ready,
  output logic              cdb_valid,
  output logic [DATA_W-1:0] cdb_data,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic              cdb_src,
  output logic              tag_err
);

  localparam int EW = TAG_W + DATA_W;

  // Handshake: a unit's result transfers on a rising edge where x_valid and
  // x_ready are both high; ready depends only on FIFO occupancy, so a sender
  // seeing ready low must keep valid, tag and data stable until it rises.
  logic              add_push, mul_push, add_zero, mul_zero;
  logic              add_full, mul_full, add_empty, mul_empty;
  logic [EW-1:0]     add_head, mul_head;
  logic [$clog2(DEPTH):0] add_count, mul_count;
  logic              grant_add, grant_mul;
  src_t              last_grant;

  assign add_ready = !add_full;
  assign mul_ready = !mul_full;
  assign add_zero  = add_valid && (add_tag == TAG_W'(TAG_NONE));
  assign mul_zero  = mul_valid && (mul_tag == TAG_W'(TAG_NONE));
  assign add_push  = add_valid && add_ready && !add_zero;
  assign mul_push  = mul_valid && mul_ready && !mul_zero;

  result_fifo #(.W(EW), .DEPTH(DEPTH)) u_add_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (add_push),
    .wdata ({add_tag, add_data}),
    .pop   (grant_add),
    .rdata (add_head),
    .full  (add_full),
    .empty (add_empty),
    .count (add_count)
  );

  result_fifo #(.W(EW), .DEPTH(DEPTH)) u_mul_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (mul_push),
    .wdata ({mul_tag, mul_data}),
    .pop   (grant_mul),
    .rdata (mul_head),
    .full  (mul_full),
    .empty (mul_empty),
    .count (mul_count)
  );

  // With both queues occupied, the side that did not win last time goes next.
  always_comb begin
    grant_add = 1'b0;
    grant_mul = 1'b0;
    if (!add_empty && !mul_empty) begin
      grant_add = (last_grant == SRC_MUL);
      grant_mul = (last_grant == SRC_ADD);
    end else begin
      grant_add = !add_empty;
      grant_mul = !mul_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= SRC_MUL;
      cdb_valid  <= 1'b0;
      cdb_data   <= '0;
      cdb_tag    <= '0;
      cdb_src    <= 1'b0;
      tag_err    <= 1'b0;
    end else begin
      cdb_valid <= grant_add || grant_mul;
      if (grant_add) begin
        last_grant <= SRC_ADD;
        cdb_src    <= SRC_ADD;
        {cdb_tag, cdb_data} <= add_head;
      end else if (grant_mul) begin
        last_grant <= SRC_MUL;
        cdb_src    <= SRC_MUL;
        {cdb_tag, cdb_data} <= mul_head;
      end
      if (add_zero || mul_zero) tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a reference queue model and expected-broadcast
// scoreboard checked every cycle on the falling edge.
module tb_cdb_arbiter;
  import tomasulo_pkg::*;

  localparam int DEPTH = 2;
  localparam int IW    = TAG_W + DATA_W;
  localparam int EW    = 1 + IW;

  logic              clk = 1'b0;
  logic              rst;
  logic              add_valid, mul_valid;
  logic [DATA_W-1:0] add_data, mul_data;
  logic [TAG_W-1:0]  add_tag, mul_tag;
  logic              add_ready, mul_ready;
  logic              cdb_valid, cdb_src, tag_err;
  logic [DATA_W-1:0] cdb_data;
  logic [TAG_W-1:0]  cdb_tag;

  always #5 clk = ~clk;

  cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .add_valid (add_valid),
    .add_data  (add_data),
    .add_tag   (add_tag),
    .add_ready (add_ready),
    .mul_valid (mul_valid),
    .mul_data  (mul_data),
    .mul_tag   (mul_tag),
    .mul_ready (mul_ready),
    .cdb_valid (cdb_valid),
    .cdb_data  (cdb_data),
    .cdb_tag   (cdb_tag),
    .cdb_src   (cdb_src),
    .tag_err   (tag_err)
  );

  int errors = 0;
  int checks = 0;

  logic [EW-1:0] exp_q[$];
  logic [IW-1:0] m_add[$], m_mul[$];
  logic [IW-1:0] add_src[$], mul_src[$];
  logic          got_src[$];
  logic [EW-1:0] last_exp;
  logic          m_last, m_tag_err, add_acc, mul_acc;
  logic          saw_mul_full;

  // Reference model: grant from pre-edge occupancy, then pop, then push.
  always @(posedge clk) begin
    logic a_ne, m_ne, a_full, mu_full, g_add, g_mul;
    if (rst) begin
      m_add.delete(); m_mul.delete(); exp_q.delete();
      m_last = 1'b1; m_tag_err = 1'b0; add_acc = 1'b0; mul_acc = 1'b0;
      last_exp = '0;
    end else begin
      a_ne = m_add.size() != 0;
      m_ne = m_mul.size() != 0;
      a_full  = m_add.size() >= DEPTH;
      mu_full = m_mul.size() >= DEPTH;
      g_add = a_ne && (!m_ne || m_last == 1'b1);
      g_mul = m_ne && (!a_ne || m_last == 1'b0);
      if (g_add) begin exp_q.push_back({1'b0, m_add.pop_front()}); m_last = 1'b0; end
      else if (g_mul) begin exp_q.push_back({1'b1, m_mul.pop_front()}); m_last = 1'b1; end
      add_acc = add_valid && !a_full && add_tag != '0;
      mul_acc = mul_valid && !mu_full && mul_tag != '0;
      if ((add_valid && add_tag == '0) || (mul_valid && mul_tag == '0)) m_tag_err = 1'b1;
      if (add_acc) m_add.push_back({add_tag, add_data});
      if (mul_acc) m_mul.push_back({mul_tag, mul_data});
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_cycle();
    chk("add_ready", 32'(add_ready), 32'(m_add.size() < DEPTH));
    chk("mul_ready", 32'(mul_ready), 32'(m_mul.size() < DEPTH));
    chk("tag_err", 32'(tag_err), 32'(m_tag_err));
    chk("cdb_valid", 32'(cdb_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) last_exp = exp_q.pop_front();
    chk("cdb_entry", 32'({cdb_src, cdb_tag, cdb_data}), 32'(last_exp));
    if (cdb_valid) got_src.push_back(cdb_src);
    if (!mul_ready) saw_mul_full = 1'b1;
  endtask

  // Sender model: hold an item until accepted (a tag-0 item is consumed by being dropped).
  task automatic feed();
    if (add_valid && (add_acc || add_tag == '0) && add_src.size() != 0) void'(add_src.pop_front());
    if (mul_valid && (mul_acc || mul_tag == '0) && mul_src.size() != 0) void'(mul_src.pop_front());
    add_valid = add_src.size() != 0;
    mul_valid = mul_src.size() != 0;
    {add_tag, add_data} = add_valid ? add_src[0] : '0;
    {mul_tag, mul_data} = mul_valid ? mul_src[0] : '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_cycle();
    feed();
  endtask

  task automatic drain();
    int n = 0;
    while ((add_src.size() + mul_src.size() + m_add.size() + m_mul.size() + exp_q.size()) != 0
           && n < 200) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n >= 200), 32'(0));
    tick();
  endtask

  task automatic reset_pulse();
    add_src.delete(); mul_src.delete();
    add_valid = 1'b0; mul_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    add_valid = 1'b0; add_data = '0; add_tag = '0;
    mul_valid = 1'b0; mul_data = '0; mul_tag = '0;
    saw_mul_full = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Idle after reset.
    repeat (5) tick();
    chk("idle_valid", 32'(cdb_valid), 32'(0));
    chk("idle_ready", 32'({add_ready, mul_ready}), 32'(2'b11));
    chk("idle_tag_err", 32'(tag_err), 32'(0));

    // Single ADD push: visible one edge after it is written, never earlier.
    add_src.push_back({3'd3, 8'h2A});
    feed();
    tick();
    chk("single_not_early", 32'(cdb_valid), 32'(0));
    tick();
    chk("single_valid", 32'(cdb_valid), 32'(1));
    chk("single_entry", 32'({cdb_src, cdb_tag, cdb_data}), 32'({1'b0, 3'd3, 8'h2A}));
    tick();
    chk("single_one_shot", 32'(cdb_valid), 32'(0));
    chk("single_hold", 32'({cdb_tag, cdb_data}), 32'({3'd3, 8'h2A}));

    // Simultaneous pair after reset: ADD wins first.
    reset_pulse();
    tick();
    got_src.delete();
    add_src.push_back({3'd1, 8'h10});
    mul_src.push_back({3'd5, 8'h20});
    feed();
    drain();
    chk("pair1_count", 32'(got_src.size()), 32'(2));
    chk("pair1_first_add", 32'(got_src[0]), 32'(0));
    chk("pair1_second_mul", 32'(got_src[1]), 32'(1));

    // A lone ADD, then another pair: MUL now goes first.
    add_src.push_back({3'd2, 8'h33});
    feed();
    drain();
    got_src.delete();
    add_src.push_back({3'd6, 8'h44});
    mul_src.push_back({3'd7, 8'h55});
    feed();
    drain();
    chk("pair2_first_mul", 32'(got_src[0]), 32'(1));
    chk("pair2_second_add", 32'(got_src[1]), 32'(0));

    // Backlogged ADD against a held MUL stream: grants alternate, MUL fills.
    got_src.delete();
    saw_mul_full = 1'b0;
    for (int i = 0; i < 6; i++) add_src.push_back({3'((i % 7) + 1), 8'($urandom_range(0, 255))});
    for (int i = 0; i < 4; i++) mul_src.push_back({3'(i + 4), 8'(8'h80 + i)});
    feed();
    drain();
    chk("backlog_count", 32'(got_src.size()), 32'(10));
    chk("backlog_mul_full_seen", 32'(saw_mul_full), 32'(1));
    for (int i = 0; i < 7; i++) chk("backlog_alternate", 32'(got_src[i] != got_src[i + 1]), 32'(1));

    // Tag 0 is dropped and latches the sticky error.
    add_src.push_back({3'd0, 8'h77});
    feed();
    tick();
    chk("tag0_err", 32'(tag_err), 32'(1));
    repeat (3) tick();
    chk("tag0_sticky", 32'(tag_err), 32'(1));
    chk("tag0_no_bcast", 32'(cdb_valid), 32'(0));

    // Fill both queues, then reset mid-flight: nothing stale is broadcast.
    for (int i = 0; i < 3; i++) begin
      add_src.push_back({3'(i + 1), 8'(8'hA0 + i)});
      mul_src.push_back({3'(i + 4), 8'(8'hB0 + i)});
    end
    feed();
    tick(); tick();
    reset_pulse();
    chk("rst_valid", 32'(cdb_valid), 32'(0));
    chk("rst_ready", 32'({add_ready, mul_ready}), 32'(2'b11));
    chk("rst_tag_err", 32'(tag_err), 32'(0));
    got_src.delete();
    repeat (4) tick();
    chk("rst_no_stale", 32'(got_src.size()), 32'(0));
    chk("final_scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
